// File: rtl/spi_pkg.sv
// Shared types and SPI mode helpers for the PIC-link frame slave.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_t;

    // SPI mode numbering is {CPOL,CPHA}.
    localparam int MODE0 = 0;
    localparam int MODE1 = 1;
    localparam int MODE2 = 2;
    localparam int MODE3 = 3;

    function automatic logic mode_cpol(input int mode);
        return ((mode / 2) % 2) != 0;
    endfunction

    function automatic logic mode_cpha(input int mode);
        return (mode % 2) != 0;
    endfunction

    // Data is sampled on the rising sck edge exactly when CPOL equals CPHA.
    function automatic logic sample_on_rise(input int mode);
        return mode_cpol(mode) == mode_cpha(mode);
    endfunction

endpackage

// File: rtl/sync_bits.sv
// Generic multi-bit synchronizer: LEN flops per bit, asynchronously cleared by reset_b.
module sync_bits
    import spi_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int LEN   = 2
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [LEN];

    // NOTE: every stage is cleared so a synced cs_b starts low and cannot fake a falling edge after reset.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < LEN; i++) stage[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage take its neighbour's pre-edge value.
            stage[0] <= din;
            for (int i = 1; i < LEN; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[LEN-1];

endmodule

// File: rtl/spi_frame_slave.sv
// Oversampling SPI frame slave in the clk domain: configurable width/mode, double-buffered
// receive data published on update, abort/overrun detection with saturating counters.
module spi_frame_slave
    import spi_pkg::*;
#(
    parameter int FRAME_W  = 32,
    parameter int MODE     = MODE1,
    parameter int SYNC_LEN = 2,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic               sck,
    input  logic               cs_b,
    input  logic               sdo,
    output logic               sdi,
    input  logic [FRAME_W-1:0] d,
    input  logic               update,
    output logic [FRAME_W-1:0] q,
    output logic               rx_new,
    output logic               pending,
    output logic               overrun,
    output logic [CNT_W-1:0]   abort_cnt,
    output logic [CNT_W-1:0]   overrun_cnt,
    input  logic               clr_err
);

    localparam int                  CNT_BITS    = $clog2(FRAME_W + 1);
    localparam logic                SAMPLE_RISE = sample_on_rise(MODE);
    localparam logic [CNT_BITS-1:0] LAST_BIT    = CNT_BITS'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

    logic sck_s, cs_b_s, sdo_s;
    logic sck_q, cs_b_q;

    sync_bits #(.WIDTH(3), .LEN(SYNC_LEN)) u_sync (
        .clk     (clk),
        .reset_b (reset_b),
        .din     ({sck, cs_b, sdo}),
        .dout    ({sck_s, cs_b_s, sdo_s})
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sck_q  <= 1'b0;
            cs_b_q <= 1'b0;
        end else begin
            sck_q  <= sck_s;
            cs_b_q <= cs_b_s;
        end
    end

    logic sck_rise, sck_fall, cs_fall, cs_rise, sample_edge, shift_edge;

    assign sck_rise    = sck_s & ~sck_q;
    assign sck_fall    = ~sck_s & sck_q;
    assign cs_fall     = ~cs_b_s & cs_b_q;
    assign cs_rise     = cs_b_s & ~cs_b_q;
    assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
    assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;

    spi_state_t          state;
    logic [CNT_BITS-1:0] cnt;
    logic [FRAME_W-2:0]  tx_sr;     // bits still to send after the one on sdi
    logic [FRAME_W-1:0]  rx_sr;
    logic                abort_evt;

    assign abort_evt = (state == SHIFT) && cs_rise && (cnt != '0);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state     <= IDLE;
            cnt       <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            sdi       <= 1'b0;
            rx_new    <= 1'b0;
            abort_cnt <= '0;
        end else begin
            rx_new <= 1'b0;

            if (clr_err)
                abort_cnt <= '0;
            else if (abort_evt && abort_cnt != CNT_MAX)
                abort_cnt <= abort_cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        tx_sr <= d[FRAME_W-2:0];
                        sdi   <= d[FRAME_W-1];
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        sdi   <= 1'b0;
                        state <= IDLE;
                    end else if (sample_edge) begin
                        rx_sr <= {rx_sr[FRAME_W-2:0], sdo_s};
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST_BIT) begin
                            rx_new <= 1'b1;
                            sdi    <= 1'b0;
                            state  <= DONE;
                        end
                    end else if (shift_edge && cnt != '0) begin
                        // A shift edge ahead of the first sample (CPHA=1 leading edge) keeps the MSB on sdi.
                        tx_sr <= {tx_sr[FRAME_W-3:0], 1'b0};
                        sdi   <= tx_sr[FRAME_W-2];
                    end
                end
                DONE: begin
                    if (cs_rise) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // rx_buf takes the finished frame at the end of the rx_new cycle, so an update in that
    // same cycle still publishes the previous frame.
    logic [FRAME_W-1:0] rx_buf;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rx_buf      <= '0;
            q           <= '0;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            if (rx_new) begin
                rx_buf  <= rx_sr;
                pending <= 1'b1;
                if (update && pending) q <= rx_buf;
            end else if (update && pending) begin
                q       <= rx_buf;
                pending <= 1'b0;
            end

            if (clr_err) begin
                overrun     <= 1'b0;
                overrun_cnt <= '0;
            end else if (rx_new && pending && !update) begin
                overrun <= 1'b1;
                if (overrun_cnt != CNT_MAX) overrun_cnt <= overrun_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Randomized bench for spi_frame_slave: a 32-bit mode-1 slave plus 8-bit slaves in modes 0..3,
// checked against a transaction-level model of the publish/overrun/abort rules.
module tb_spi_frame_slave;

    localparam int NU   = 5;   // unit 0: 32-bit mode 1; units 1..4: 8-bit modes 0..3
    localparam int HALF = 8;   // clk cycles per sck half period
    localparam int LAT  = 3;   // SYNC_LEN + 1

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        sck [NU];
    logic        cs_b [NU];
    logic        sdo [NU];
    logic        update [NU];
    logic        clr_err [NU];
    logic        sdi_w [NU];
    logic        rx_new_w [NU];
    logic        pending_w [NU];
    logic        overrun_w [NU];
    logic [7:0]  abort_w [NU];
    logic [7:0]  ovcnt_w [NU];
    logic [31:0] d0, q0;
    logic [7:0]  d8 [4];
    logic [7:0]  q8 [4];

    int n_checks = 0;
    int n_pass   = 0;
    int rx_cnt [NU] = '{default: 0};

    logic [31:0] last_miso;
    int          last_lat;

    // Reference model of unit 0
    logic [31:0] m_q, m_buf;
    logic        m_pend, m_ovr;
    logic [7:0]  m_abort, m_ovcnt;
    int          m_rx;

    always #5 clk = ~clk;

    spi_frame_slave #(.FRAME_W(32), .MODE(1), .SYNC_LEN(2), .CNT_W(8)) dut0 (
        .clk(clk), .reset_b(reset_b), .sck(sck[0]), .cs_b(cs_b[0]), .sdo(sdo[0]),
        .sdi(sdi_w[0]), .d(d0), .update(update[0]), .q(q0), .rx_new(rx_new_w[0]),
        .pending(pending_w[0]), .overrun(overrun_w[0]), .abort_cnt(abort_w[0]),
        .overrun_cnt(ovcnt_w[0]), .clr_err(clr_err[0])
    );

    for (genvar k = 1; k < NU; k++) begin : g_byte
        spi_frame_slave #(.FRAME_W(8), .MODE(k - 1), .SYNC_LEN(2), .CNT_W(8)) dut (
            .clk(clk), .reset_b(reset_b), .sck(sck[k]), .cs_b(cs_b[k]), .sdo(sdo[k]),
            .sdi(sdi_w[k]), .d(d8[k-1]), .update(update[k]), .q(q8[k-1]), .rx_new(rx_new_w[k]),
            .pending(pending_w[k]), .overrun(overrun_w[k]), .abort_cnt(abort_w[k]),
            .overrun_cnt(ovcnt_w[k]), .clr_err(clr_err[k])
        );
    end

    always @(negedge clk) begin
        for (int u = 0; u < NU; u++)
            if (rx_new_w[u] === 1'b1) rx_cnt[u] = rx_cnt[u] + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int width_of(input int u);
        return (u == 0) ? 32 : 8;
    endfunction

    function automatic int mode_of(input int u);
        return (u == 0) ? 1 : u - 1;
    endfunction

    function automatic logic [31:0] q_of(input int u);
        return (u == 0) ? q0 : {24'h0, q8[u-1]};
    endfunction

    // Wait out the rest of the half period after the final sample edge, noting when rx_new shows.
    task automatic poll(input int u, input bit upd_same);
        last_lat = 0;
        for (int c = 1; c <= HALF; c++) begin
            @(negedge clk);
            update[u] = 1'b0;
            if (last_lat == 0 && rx_new_w[u] === 1'b1) begin
                last_lat = c;
                if (upd_same) update[u] = 1'b1;
            end
        end
        update[u] = 1'b0;
    endtask

    // Master side of nbits bits, MSB first; records the bits seen on sdi at each sample edge.
    task automatic clock_bits(input int u, input logic [31:0] data, input int nbits, input bit upd_same);
        int   w;
        logic cpol, cpha, b;
        w    = width_of(u);
        cpol = (mode_of(u) >= 2);
        cpha = (mode_of(u) % 2) != 0;
        last_miso = '0;
        last_lat  = 0;
        for (int i = 0; i < nbits; i++) begin
            b = data[w-1-i];
            if (cpha) sck[u] = ~cpol;
            sdo[u] = b;
            tick(HALF);
            last_miso = {last_miso[30:0], sdi_w[u]};
            sck[u] = cpha ? cpol : ~cpol;
            if (i == w - 1) poll(u, upd_same);
            else tick(HALF);
            if (!cpha) sck[u] = cpol;
        end
        if (!cpha && nbits > 0) tick(HALF);
    endtask

    task automatic xfer(input int u, input logic [31:0] data, input int nbits, input bit upd_same);
        cs_b[u] = 1'b0;
        tick(HALF);
        clock_bits(u, data, nbits, upd_same);
        tick(2);
        cs_b[u] = 1'b1;
        tick(HALF);
    endtask

    task automatic check_state0(input string tag);
        check({tag, ".q"},       q0,                 m_q);
        check({tag, ".pending"}, 32'(pending_w[0]),  32'(m_pend));
        check({tag, ".overrun"}, 32'(overrun_w[0]),  32'(m_ovr));
        check({tag, ".abort"},   32'(abort_w[0]),    32'(m_abort));
        check({tag, ".ovcnt"},   32'(ovcnt_w[0]),    32'(m_ovcnt));
        check({tag, ".rx_new"},  32'(rx_cnt[0]),     32'(m_rx));
    endtask

    task automatic model_reset();
        m_q = '0; m_buf = '0; m_pend = 1'b0; m_ovr = 1'b0;
        m_abort = '0; m_ovcnt = '0;
    endtask

    task automatic frame0(input string tag, input logic [31:0] data, input logic [31:0] dval, input bit upd_same);
        d0 = dval;
        xfer(0, data, 32, upd_same);
        check({tag, ".miso"}, last_miso, dval);
        check({tag, ".lat"}, 32'(last_lat), 32'(LAT));
        m_rx++;
        if (m_pend && upd_same) m_q = m_buf;
        else if (m_pend) begin
            m_ovr = 1'b1;
            if (m_ovcnt != 8'hFF) m_ovcnt++;
        end
        m_buf  = data;
        m_pend = 1'b1;
        check_state0(tag);
    endtask

    task automatic abort0(input string tag, input logic [31:0] data, input int nbits, input bit do_check);
        d0 = $urandom;
        xfer(0, data, nbits, 1'b0);
        if (nbits > 0 && m_abort != 8'hFF) m_abort++;
        if (do_check) check_state0(tag);
    endtask

    task automatic upd0(input string tag);
        @(negedge clk) update[0] = 1'b1;
        @(negedge clk) update[0] = 1'b0;
        tick(1);
        if (m_pend) begin
            m_q    = m_buf;
            m_pend = 1'b0;
        end
        check_state0(tag);
    endtask

    task automatic clr0(input string tag);
        @(negedge clk) clr_err[0] = 1'b1;
        @(negedge clk) clr_err[0] = 1'b0;
        tick(1);
        m_ovr = 1'b0; m_abort = '0; m_ovcnt = '0;
        check_state0(tag);
    endtask

    task automatic upd_unit(input int u);
        @(negedge clk) update[u] = 1'b1;
        @(negedge clk) update[u] = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [31:0] p, r;
        int          saved;
        for (int u = 0; u < NU; u++) begin
            sck[u] = (mode_of(u) >= 2); cs_b[u] = 1'b1; sdo[u] = 1'b0;
            update[u] = 1'b0; clr_err[u] = 1'b0;
        end
        d0 = '0;
        for (int k = 0; k < 4; k++) d8[k] = '0;
        model_reset();
        m_rx = 0;

        tick(4);
        reset_b = 1'b1;
        tick(HALF);
        check_state0("reset");
        check("reset.sdi", 32'(sdi_w[0]), 32'h0);

        // Mode 1, 32-bit reference frame
        frame0("m1", 32'hA5C3_0F81, 32'h1234_5678, 1'b0);
        upd0("m1_upd");
        check("m1_q", q0, 32'hA5C3_0F81);

        // Every SPI mode on 8-bit frames
        for (int u = 1; u < NU; u++) begin
            for (int f = 0; f < 2; f++) begin
                p = (f == 0) ? 32'h5A : 32'($urandom_range(0, 255));
                d8[u-1] = 8'($urandom);
                xfer(u, p, 8, 1'b0);
                check($sformatf("mode%0d.miso", u - 1), 32'(last_miso[7:0]), 32'(d8[u-1]));
                check($sformatf("mode%0d.lat", u - 1), 32'(last_lat), 32'(LAT));
                upd_unit(u);
                check($sformatf("mode%0d.q", u - 1), q_of(u), p);
            end
            check($sformatf("mode%0d.rx_cnt", u - 1), 32'(rx_cnt[u]), 32'd2);
            check($sformatf("mode%0d.pending", u - 1), 32'(pending_w[u]), 32'h0);
            check($sformatf("mode%0d.errs", u - 1),
                  {15'h0, overrun_w[u], ovcnt_w[u], abort_w[u]}, 32'h0);
        end

        // Overrun: two frames with no update between
        frame0("ovr1", 32'h1111_1111, $urandom, 1'b0);
        frame0("ovr2", 32'h2222_2222, $urandom, 1'b0);
        check("ovr_flag", 32'(overrun_w[0]), 32'h1);
        check("ovr_cnt", 32'(ovcnt_w[0]), 32'h1);
        upd0("ovr_upd");
        check("ovr_q", q0, 32'h2222_2222);
        clr0("ovr_clr");

        // Abort after 13 bits leaves pending and q alone
        frame0("pre_abort", $urandom, $urandom, 1'b0);
        abort0("abort13", $urandom, 13, 1'b1);
        check("abort13_cnt", 32'(abort_w[0]), 32'h1);
        upd0("abort_upd");
        frame0("beef", 32'hDEAD_BEEF, $urandom, 1'b0);
        upd0("beef_upd");
        check("beef_q", q0, 32'hDEAD_BEEF);

        // rx_new coinciding with update
        p = $urandom;
        r = $urandom;
        frame0("same_a", p, $urandom, 1'b0);
        frame0("same_b", r, $urandom, 1'b1);
        check("same_q", q0, p);
        check("same_pending", 32'(pending_w[0]), 32'h1);
        check("same_overrun", 32'(overrun_w[0]), 32'h0);
        upd0("same_upd");

        // Random mix of frames, aborts (including zero-bit ones), updates and clears
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 4))
                0, 1: frame0($sformatf("rnd%0d_frame", it), $urandom, $urandom, 1'($urandom_range(0, 1)));
                2:    abort0($sformatf("rnd%0d_abort", it), $urandom, $urandom_range(0, 31), 1'b1);
                3:    upd0($sformatf("rnd%0d_upd", it));
                default: clr0($sformatf("rnd%0d_clr", it));
            endcase
        end

        // One-cycle reset in the middle of a frame, cs_b still low afterwards
        cs_b[0] = 1'b0;
        tick(HALF);
        clock_bits(0, $urandom, 13, 1'b0);
        @(negedge clk) reset_b = 1'b0;
        @(negedge clk) reset_b = 1'b1;
        tick(1);
        model_reset();
        check_state0("midrst");
        check("midrst.sdi", 32'(sdi_w[0]), 32'h0);
        saved = rx_cnt[0];
        clock_bits(0, $urandom, 32, 1'b0);
        check("midrst.no_frame", 32'(last_lat), 32'h0);
        check("midrst.rx_cnt", 32'(rx_cnt[0]), 32'(saved));
        tick(2);
        cs_b[0] = 1'b1;
        tick(HALF);
        frame0("post_rst", $urandom, $urandom, 1'b0);
        upd0("post_rst_upd");

        // Abort counter saturation
        clr0("sat_pre");
        for (int i = 0; i < 300; i++) abort0("sat", $urandom, $urandom_range(1, 3), 1'b0);
        check_state0("sat");
        check("sat_255", 32'(abort_w[0]), 32'd255);
        clr0("sat_clr");
        check("sat_zero", 32'(abort_w[0]), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
